// File: rtl/axi4lite_pkg.sv
// Shared AXI4-Lite widths, response codes and the byte-strobe merge helper.
package axi4lite_pkg;

    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB       = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] dat;
        logic [AXI_STRB_WIDTH-1:0] strb;
        logic [1:0]                resp;
    } wr_cmt_t;

    function automatic logic [AXI_DATA_WIDTH-1:0] strb_merge(
        input logic [AXI_DATA_WIDTH-1:0] old_dat,
        input logic [AXI_DATA_WIDTH-1:0] new_dat,
        input logic [AXI_STRB_WIDTH-1:0] strb
    );
        logic [AXI_DATA_WIDTH-1:0] res;
        res = old_dat;
        for (int k = 0; k < AXI_STRB_WIDTH; k++) begin
            if (strb[k]) res[k*8 +: 8] = new_dat[k*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/axi4lite_if.sv
// AXI4-Lite link: five channels with master/slave views.
interface axi4lite_if;
    import axi4lite_pkg::*;

    logic                      AW_VALID;
    logic                      AW_READY;
    logic [AXI_ADDR_WIDTH-1:0] AW_ADDR;
    logic [2:0]                AW_PROT;
    logic                      W_VALID;
    logic                      W_READY;
    logic [AXI_DATA_WIDTH-1:0] W_DATA;
    logic [AXI_STRB_WIDTH-1:0] W_STRB;
    logic                      B_VALID;
    logic                      B_READY;
    logic [1:0]                B_RESP;
    logic                      AR_VALID;
    logic                      AR_READY;
    logic [AXI_ADDR_WIDTH-1:0] AR_ADDR;
    logic [2:0]                AR_PROT;
    logic                      R_VALID;
    logic                      R_READY;
    logic [AXI_DATA_WIDTH-1:0] R_DATA;
    logic [1:0]                R_RESP;

    modport master (
        output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport slave (
        input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

endinterface

// File: rtl/axi4lite_wr_ctrl.sv
// AXI4-Lite write control: one-entry AW and W slots, commit request, B channel.
// Latency: commit one cycle after both slots fill; B_VALID the cycle after commit.
// Backpressure: a held B blocks commits only; each slot deasserts READY while full.
module axi4lite_wr_ctrl
    import axi4lite_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3
) (
    input  logic             A_CLK,
    input  logic             A_RST,
    axi4lite_if.slave        s_axi,
    output logic             cmt_vld,
    output logic [IDX_W-1:0] cmt_idx,
    output wr_cmt_t          cmt_dat
);

    logic                      aw_full;
    logic                      w_full;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr;
    logic [AXI_DATA_WIDTH-1:0] w_data;
    logic [AXI_STRB_WIDTH-1:0] w_strb;
    logic [AXI_ADDR_WIDTH-1:0] aw_word;
    logic [1:0]                aw_resp;

    assign aw_word = aw_addr >> ADDR_LSB;
    assign aw_resp = (aw_word < AXI_ADDR_WIDTH'(NUM_REGS)) ? RESP_OKAY : RESP_SLVERR;

    assign s_axi.AW_READY = !aw_full && !A_RST;
    assign s_axi.W_READY  = !w_full && !A_RST;

    assign cmt_vld = aw_full && w_full && !s_axi.B_VALID;
    assign cmt_idx = IDX_W'(aw_word);
    assign cmt_dat = '{dat: w_data, strb: w_strb, resp: aw_resp};

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            aw_full       <= 1'b0;
            w_full        <= 1'b0;
            aw_addr       <= '0;
            w_data        <= '0;
            w_strb        <= '0;
            s_axi.B_VALID <= 1'b0;
            s_axi.B_RESP  <= RESP_OKAY;
        end else begin
            if (s_axi.AW_VALID && s_axi.AW_READY) begin
                aw_full <= 1'b1;
                aw_addr <= s_axi.AW_ADDR;
            end
            if (s_axi.W_VALID && s_axi.W_READY) begin
                w_full <= 1'b1;
                w_data <= s_axi.W_DATA;
                w_strb <= s_axi.W_STRB;
            end
            // Both slots are full during a commit, so no capture can collide with the clear.
            if (cmt_vld) begin
                aw_full       <= 1'b0;
                w_full        <= 1'b0;
                s_axi.B_VALID <= 1'b1;
                s_axi.B_RESP  <= aw_resp;
            end else if (s_axi.B_VALID && s_axi.B_READY) begin
                s_axi.B_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS strobed R/W registers with write pulses.
// Latency: write B/REG_OUT two cycles after AW+W handshake; read R one cycle after AR.
// Backpressure: B_VALID/R_VALID held until READY; AR_READY low while R_VALID high.
module axi4lite_reg_slave
    import axi4lite_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                               A_CLK,
    input  logic                               A_RST,
    axi4lite_if.slave                          s_axi,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] REG_OUT,
    output logic [NUM_REGS-1:0]                WR_PULSE
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                      cmt_vld;
    logic [IDX_W-1:0]          cmt_idx;
    wr_cmt_t                   cmt_dat;
    logic [AXI_DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [AXI_ADDR_WIDTH-1:0] ar_word;
    logic                      ar_in_range;
    logic                      unused_prot;

    assign unused_prot = ^{s_axi.AW_PROT, s_axi.AR_PROT};

    axi4lite_wr_ctrl #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_wr_ctrl (
        .A_CLK   (A_CLK),
        .A_RST   (A_RST),
        .s_axi   (s_axi),
        .cmt_vld (cmt_vld),
        .cmt_idx (cmt_idx),
        .cmt_dat (cmt_dat)
    );

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            WR_PULSE <= '0;
        end else begin
            WR_PULSE <= '0;
            if (cmt_vld && cmt_dat.resp == RESP_OKAY) begin
                regs[cmt_idx]     <= strb_merge(regs[cmt_idx], cmt_dat.dat, cmt_dat.strb);
                WR_PULSE[cmt_idx] <= 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign REG_OUT[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = regs[i];
    end

    assign ar_word        = s_axi.AR_ADDR >> ADDR_LSB;
    assign ar_in_range    = ar_word < AXI_ADDR_WIDTH'(NUM_REGS);
    assign s_axi.AR_READY = !s_axi.R_VALID && !A_RST;

    // Sampling regs with non-blocking semantics gives the pre-write value on a coincident commit.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            s_axi.R_VALID <= 1'b0;
            s_axi.R_DATA  <= '0;
            s_axi.R_RESP  <= RESP_OKAY;
        end else if (s_axi.AR_VALID && s_axi.AR_READY) begin
            s_axi.R_VALID <= 1'b1;
            s_axi.R_DATA  <= ar_in_range ? regs[IDX_W'(ar_word)] : '0;
            s_axi.R_RESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (s_axi.R_READY) begin
            s_axi.R_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Scenario bench for axi4lite_reg_slave against an array-based register model.
module tb_axi4lite_reg_slave;
    import axi4lite_pkg::*;

    localparam int NREG = 8;

    logic                 A_CLK = 1'b0;
    logic                 A_RST = 1'b1;
    logic [NREG*32-1:0]   REG_OUT;
    logic [NREG-1:0]      WR_PULSE;
    int                   vectors = 0;
    int                   miscompares = 0;
    logic [31:0]          model [NREG];

    axi4lite_if bus();

    axi4lite_reg_slave #(.NUM_REGS(NREG)) dut (
        .A_CLK    (A_CLK),
        .A_RST    (A_RST),
        .s_axi    (bus),
        .REG_OUT  (REG_OUT),
        .WR_PULSE (WR_PULSE)
    );

    always #5 A_CLK = ~A_CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (d & m);
    endfunction

    function automatic logic [NREG*32-1:0] model_flat();
        logic [NREG*32-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge A_CLK);
        #1;
    endtask

    task automatic idle();
        bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.AW_PROT = '0;
        bus.W_VALID  = 1'b0; bus.W_DATA  = '0; bus.W_STRB  = '0;
        bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.AR_PROT = '0;
        bus.B_READY  = 1'b1; bus.R_READY = 1'b1;
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly);
        repeat (dly) tick();
        bus.AW_ADDR = a; bus.AW_PROT = 3'($urandom); bus.AW_VALID = 1'b1;
        for (int i = 0; i < 16 && !bus.AW_READY; i++) tick();
        tick();
        bus.AW_VALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        repeat (dly) tick();
        bus.W_DATA = d; bus.W_STRB = s; bus.W_VALID = 1'b1;
        for (int i = 0; i < 16 && !bus.W_READY; i++) tick();
        tick();
        bus.W_VALID = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly);
        fork
            send_aw(a, aw_dly);
            send_w(d, s, w_dly);
        join
    endtask

    task automatic wait_b(output bit got, output logic [1:0] resp, output logic [NREG-1:0] pulse);
        got = 1'b0; resp = 'x; pulse = 'x;
        for (int i = 0; i < 16; i++) begin
            if (bus.B_VALID) begin
                got = 1'b1; resp = bus.B_RESP; pulse = WR_PULSE;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic do_read(input logic [31:0] a, output bit got, output logic [31:0] d, output logic [1:0] r);
        bus.AR_ADDR = a; bus.AR_PROT = 3'($urandom); bus.AR_VALID = 1'b1;
        for (int i = 0; i < 16 && !bus.AR_READY; i++) tick();
        tick();
        bus.AR_VALID = 1'b0;
        got = 1'b0; d = 'x; r = 'x;
        for (int i = 0; i < 16; i++) begin
            if (bus.R_VALID) begin
                got = 1'b1; d = bus.R_DATA; r = bus.R_RESP;
                break;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        idle();
        for (int i = 0; i < NREG; i++) model[i] = '0;
        repeat (3) tick();
        vectors++; if ({bus.AW_READY, bus.W_READY, bus.AR_READY} !== 3'b000) begin miscompares++; $display("FAIL reset_ready_in_rst: got %b want 000", {bus.AW_READY, bus.W_READY, bus.AR_READY}); end
        A_RST = 1'b0;
        #1;
        vectors++; if ({bus.AW_READY, bus.W_READY, bus.AR_READY} !== 3'b111) begin miscompares++; $display("FAIL reset_ready_after: got %b want 111", {bus.AW_READY, bus.W_READY, bus.AR_READY}); end
        vectors++; if ({bus.B_VALID, bus.R_VALID} !== 2'b00) begin miscompares++; $display("FAIL reset_valids: got %b want 00", {bus.B_VALID, bus.R_VALID}); end
        vectors++; if ({bus.B_RESP, bus.R_RESP} !== 4'b0000) begin miscompares++; $display("FAIL reset_resps: got %b want 0000", {bus.B_RESP, bus.R_RESP}); end
        vectors++; if (bus.R_DATA !== 32'h0) begin miscompares++; $display("FAIL reset_rdata: got %h want 0", bus.R_DATA); end
        vectors++; if (WR_PULSE !== '0) begin miscompares++; $display("FAIL reset_pulse: got %b want 0", WR_PULSE); end
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL reset_regs: got %h want %h", REG_OUT, model_flat()); end
        tick();
    endtask

    task automatic test_aligned_write();
        bus.AW_ADDR = 32'h4; bus.W_DATA = 32'hDEADBEEF; bus.W_STRB = 4'hF;
        bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        vectors++; if (bus.B_VALID !== 1'b0) begin miscompares++; $display("FAIL aligned_bvalid_early: got %b want 0", bus.B_VALID); end
        tick();
        model[1] = ref_merge(model[1], 32'hDEADBEEF, 4'hF);
        vectors++; if (bus.B_VALID !== 1'b1) begin miscompares++; $display("FAIL aligned_bvalid: got %b want 1", bus.B_VALID); end
        vectors++; if (bus.B_RESP !== RESP_OKAY) begin miscompares++; $display("FAIL aligned_bresp: got %b want 00", bus.B_RESP); end
        vectors++; if (WR_PULSE !== 8'h02) begin miscompares++; $display("FAIL aligned_pulse: got %h want 02", WR_PULSE); end
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL aligned_regs: got %h want %h", REG_OUT, model_flat()); end
        tick();
        vectors++; if ({bus.B_VALID, WR_PULSE} !== 9'h0) begin miscompares++; $display("FAIL aligned_pulse_end: got %b/%h want 0/00", bus.B_VALID, WR_PULSE); end
    endtask

    task automatic test_w_before_aw();
        bus.W_DATA = 32'h11223344; bus.W_STRB = 4'b0101; bus.W_VALID = 1'b1;
        tick();
        bus.W_VALID = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vectors++; if ({bus.AW_READY, bus.W_READY} !== 2'b10) begin miscompares++; $display("FAIL wfirst_ready_c%0d: got %b want 10", c, {bus.AW_READY, bus.W_READY}); end
            if (c < 2) tick();
        end
        bus.AW_ADDR = 32'h4; bus.AW_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0;
        tick();
        model[1] = ref_merge(model[1], 32'h11223344, 4'b0101);
        vectors++; if ({bus.B_VALID, bus.B_RESP} !== 3'b100) begin miscompares++; $display("FAIL wfirst_b: got %b want 100", {bus.B_VALID, bus.B_RESP}); end
        vectors++; if (REG_OUT[63:32] !== 32'hDE22BE44) begin miscompares++; $display("FAIL wfirst_reg1: got %h want de22be44", REG_OUT[63:32]); end
        tick();
    endtask

    task automatic test_out_of_range();
        bit got; logic [1:0] r; logic [NREG-1:0] p; logic [31:0] d;
        do_write(32'h20, $urandom, 4'hF, 0, 0);
        wait_b(got, r, p);
        vectors++; if (!got || r !== RESP_SLVERR) begin miscompares++; $display("FAIL oor_wr_resp: got %b/%b want 1/10", got, r); end
        vectors++; if (p !== '0) begin miscompares++; $display("FAIL oor_wr_pulse: got %h want 00", p); end
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL oor_wr_regs: got %h want %h", REG_OUT, model_flat()); end
        do_read(32'h20, got, d, r);
        vectors++; if (!got || d !== 32'h0 || r !== RESP_SLVERR) begin miscompares++; $display("FAIL oor_rd: got %b/%h/%b want 1/0/10", got, d, r); end
        do_read(32'h1F, got, d, r);
        vectors++; if (!got || d !== model[7] || r !== RESP_OKAY) begin miscompares++; $display("FAIL last_reg_rd: got %b/%h/%b want 1/%h/00", got, d, r, model[7]); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d2;
        d2 = $urandom;
        bus.B_READY = 1'b0;
        do_write(32'h24, $urandom, 4'hF, 0, 0);
        for (int i = 0; i < 8 && !bus.B_VALID; i++) tick();
        do_write(32'h10, d2, 4'hF, 1, 0);
        for (int c = 0; c < 5; c++) begin
            vectors++; if ({bus.B_VALID, bus.B_RESP, bus.AW_READY, bus.W_READY} !== 5'b11000) begin miscompares++; $display("FAIL bp_hold_c%0d: got %b want 11000", c, {bus.B_VALID, bus.B_RESP, bus.AW_READY, bus.W_READY}); end
            vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL bp_nocommit_c%0d: got %h want %h", c, REG_OUT, model_flat()); end
            tick();
        end
        bus.B_READY = 1'b1;
        tick();
        vectors++; if (bus.B_VALID !== 1'b0) begin miscompares++; $display("FAIL bp_b_drop: got %b want 0", bus.B_VALID); end
        tick();
        model[4] = ref_merge(model[4], d2, 4'hF);
        vectors++; if ({bus.B_VALID, bus.B_RESP} !== 3'b100 || WR_PULSE !== 8'h10) begin miscompares++; $display("FAIL bp_second_b: got %b/%h want 100/10", {bus.B_VALID, bus.B_RESP}, WR_PULSE); end
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL bp_second_regs: got %h want %h", REG_OUT, model_flat()); end
        tick();
    endtask

    task automatic test_read_during_commit();
        bit got; logic [31:0] d; logic [1:0] r; logic [31:0] old;
        old = model[2];
        bus.AW_ADDR = 32'h8; bus.W_DATA = 32'h5A5A5A5A; bus.W_STRB = 4'hF;
        bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        bus.AR_ADDR = 32'h8; bus.AR_VALID = 1'b1;
        vectors++; if (bus.AR_READY !== 1'b1) begin miscompares++; $display("FAIL rdc_arready: got %b want 1", bus.AR_READY); end
        tick();
        bus.AR_VALID = 1'b0;
        model[2] = ref_merge(model[2], 32'h5A5A5A5A, 4'hF);
        vectors++; if ({bus.R_VALID, bus.R_RESP} !== 3'b100 || bus.R_DATA !== old) begin miscompares++; $display("FAIL rdc_old_value: got %b/%h want 100/%h", {bus.R_VALID, bus.R_RESP}, bus.R_DATA, old); end
        vectors++; if (bus.B_VALID !== 1'b1 || REG_OUT !== model_flat()) begin miscompares++; $display("FAIL rdc_commit: got %b/%h want 1/%h", bus.B_VALID, REG_OUT, model_flat()); end
        tick();
        do_read(32'h8, got, d, r);
        vectors++; if (!got || d !== 32'h5A5A5A5A || r !== RESP_OKAY) begin miscompares++; $display("FAIL rdc_new_value: got %b/%h/%b want 1/5a5a5a5a/00", got, d, r); end
    endtask

    task automatic test_back_to_back();
        int hs = 0;
        int rhs = 0;
        logic [31:0] last = '0;
        bus.AW_ADDR = 32'h14; bus.W_STRB = 4'hF; bus.W_DATA = $urandom;
        bus.AR_ADDR = 32'h14;
        bus.AW_VALID = 1'b1; bus.W_VALID = 1'b1; bus.AR_VALID = 1'b1;
        for (int c = 0; c < 8; c++) begin
            bit took;
            took = bus.AW_READY && bus.W_READY;
            if (took) begin hs++; last = bus.W_DATA; end
            if (bus.AR_READY) rhs++;
            tick();
            if (took) bus.W_DATA = $urandom;
        end
        bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0; bus.AR_VALID = 1'b0;
        model[5] = last;
        vectors++; if (hs !== 4) begin miscompares++; $display("FAIL b2b_write_rate: got %0d want 4", hs); end
        vectors++; if (rhs !== 4) begin miscompares++; $display("FAIL b2b_read_rate: got %0d want 4", rhs); end
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL b2b_regs: got %h want %h", REG_OUT, model_flat()); end
        tick();
    endtask

    task automatic test_random();
        bit got; logic [1:0] r; logic [NREG-1:0] p; logic [31:0] d;
        for (int n = 0; n < 40; n++) begin
            int idx;
            logic [31:0] a;
            idx = int'($urandom_range(0, 9));
            a = 32'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) != 0) begin
                logic [31:0] wd; logic [3:0] ws;
                wd = $urandom; ws = 4'($urandom);
                do_write(a, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
                wait_b(got, r, p);
                if (idx < NREG) model[idx] = ref_merge(model[idx], wd, ws);
                vectors++; if (!got || r !== ((idx < NREG) ? RESP_OKAY : RESP_SLVERR)) begin miscompares++; $display("FAIL rnd_wr_resp_%0d: got %b/%b idx %0d", n, got, r, idx); end
                vectors++; if (p !== ((idx < NREG) ? NREG'(1) << idx : '0)) begin miscompares++; $display("FAIL rnd_wr_pulse_%0d: got %h idx %0d", n, p, idx); end
                vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL rnd_wr_regs_%0d: got %h want %h", n, REG_OUT, model_flat()); end
            end else begin
                do_read(a, got, d, r);
                vectors++; if (!got || d !== ((idx < NREG) ? model[idx % NREG] : 32'h0) || r !== ((idx < NREG) ? RESP_OKAY : RESP_SLVERR)) begin miscompares++; $display("FAIL rnd_rd_%0d: got %b/%h/%b idx %0d", n, got, d, r, idx); end
            end
        end
    endtask

    task automatic test_mid_reset();
        bit any_b = 1'b0;
        logic [NREG-1:0] any_p = '0;
        bus.AW_ADDR = 32'h18; bus.AW_VALID = 1'b1;
        tick();
        bus.AW_VALID = 1'b0;
        bus.R_READY = 1'b0;
        bus.AR_ADDR = 32'h4; bus.AR_VALID = 1'b1;
        tick();
        bus.AR_VALID = 1'b0;
        vectors++; if (bus.R_VALID !== 1'b1) begin miscompares++; $display("FAIL mrst_rvalid_pre: got %b want 1", bus.R_VALID); end
        A_RST = 1'b1;
        tick();
        A_RST = 1'b0;
        bus.R_READY = 1'b1;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        #1;
        vectors++; if (REG_OUT !== model_flat()) begin miscompares++; $display("FAIL mrst_regs: got %h want 0", REG_OUT); end
        vectors++; if ({bus.R_VALID, bus.B_VALID, bus.AW_READY, bus.W_READY} !== 4'b0011) begin miscompares++; $display("FAIL mrst_state: got %b want 0011", {bus.R_VALID, bus.B_VALID, bus.AW_READY, bus.W_READY}); end
        tick();
        bus.W_DATA = $urandom; bus.W_STRB = 4'hF; bus.W_VALID = 1'b1;
        tick();
        bus.W_VALID = 1'b0;
        for (int c = 0; c < 4; c++) begin
            any_b |= bus.B_VALID;
            any_p |= WR_PULSE;
            tick();
        end
        vectors++; if (any_b !== 1'b0 || any_p !== '0) begin miscompares++; $display("FAIL mrst_w_alone: got b=%b pulse=%h want 0/00", any_b, any_p); end
        vectors++; if (REG_OUT !== model_flat() || bus.W_READY !== 1'b0) begin miscompares++; $display("FAIL mrst_w_held: got %h/%b want 0/0", REG_OUT, bus.W_READY); end
    endtask

    initial begin
        test_reset();
        test_aligned_write();
        test_w_before_aw();
        test_out_of_range();
        test_backpressure();
        test_read_during_commit();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
